// File: rtl/wb_slave_mux_ctrl_if.sv
// wb_slave_mux_ctrl_if: management-master bus, user/debug slave handshakes and shared slave pass-through
interface wb_slave_mux_ctrl_if;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        u_cyc_o, u_stb_o, u_ack_i;
  logic [31:0] u_dat_i;
  logic        d_cyc_o, d_stb_o, d_ack_i;
  logic [31:0] d_dat_i;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  u_ack_i, u_dat_i, d_ack_i, d_dat_i,
    output wbs_ack_o, wbs_dat_o, u_cyc_o, u_stb_o, d_cyc_o, d_stb_o,
    output s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output u_ack_i, u_dat_i, d_ack_i, d_dat_i,
    input  wbs_ack_o, wbs_dat_o, u_cyc_o, u_stb_o, d_cyc_o, d_stb_o,
    input  s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_slave_mux_ctrl.sv
// wb_slave_mux_ctrl: registered Wishbone controller steering to user/debug slave with timeout termination
module wb_slave_mux_ctrl #(
  parameter int          TIMEOUT   = 16,
  parameter logic [28:0] DEBUG_TAG = 29'h601FFFF,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  wb_slave_mux_ctrl_if.slave         bus,
  output logic                       timeout_o,
  output logic [7:0]                 err_cnt_o
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic        sel_dbg_q, sel_dbg_d, to_q, to_d;
  logic [7:0]  timer_q, timer_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        slv_ack, busy, ack;
  logic [31:0] slv_dat;
  assign slv_ack = sel_dbg_q ? bus.d_ack_i : bus.u_ack_i;
  assign slv_dat = sel_dbg_q ? bus.d_dat_i : bus.u_dat_i;
  assign busy    = state_q == BUSY;
  assign ack     = state_q == ACK;
  always_comb begin
    state_d   = state_q;
    sel_dbg_d = sel_dbg_q;
    timer_d   = timer_q;
    dat_d     = dat_q;
    to_d      = to_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
        sel_dbg_d = bus.wbs_adr_i[31:3] == DEBUG_TAG;
        timer_d   = '0;
        state_d   = BUSY;
      end
      BUSY: if (!bus.wbs_cyc_i) begin
        state_d = IDLE;
      end else if (slv_ack) begin
        dat_d   = slv_dat;
        to_d    = 1'b0;
        state_d = ACK;
      end else if (timer_q == TIMER_LAST) begin
        dat_d   = ERR_DATA;
        to_d    = 1'b1;
        err_d   = err_q + {7'd0, err_q != 8'hFF};
        state_d = ACK;
      end else begin
        timer_d = timer_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      sel_dbg_q <= 1'b0;
      timer_q   <= '0;
      dat_q     <= '0;
      to_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_dbg_q <= sel_dbg_d;
      timer_q   <= timer_d;
      dat_q     <= dat_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end
  assign bus.u_cyc_o   = busy & ~sel_dbg_q;
  assign bus.u_stb_o   = busy & ~sel_dbg_q;
  assign bus.d_cyc_o   = busy & sel_dbg_q;
  assign bus.d_stb_o   = busy & sel_dbg_q;
  assign bus.wbs_ack_o = ack;
  assign bus.wbs_dat_o = ack ? dat_q : '0;
  assign bus.s_we_o    = bus.wbs_we_i;
  assign bus.s_sel_o   = bus.wbs_sel_i;
  assign bus.s_adr_o   = bus.wbs_adr_i;
  assign bus.s_dat_o   = bus.wbs_dat_i;
  assign timeout_o     = ack & to_q;
  assign err_cnt_o     = err_q;
endmodule

// File: tb/tb_wb_slave_mux_ctrl.sv
// tb_wb_slave_mux_ctrl: vector table plus hand sequences, scoreboarded against wb_slave_mux_ctrl
module tb_wb_slave_mux_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       timeout_o;
  logic [7:0] err_cnt_o;
  int         total = 0;
  int         bad = 0;
  int         exp_err = 0;
  wb_slave_mux_ctrl_if bus ();
  wb_slave_mux_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus),
    .timeout_o (timeout_o),
    .err_cnt_o (err_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          ack_at;
    logic [31:0] rdat;
    logic        wrong;
    logic        adr_chg;
    logic [31:0] exp_dat;
    logic        exp_to;
    logic        exp_dbg;
    int          exp_stb;
  } vec_t;
  typedef struct {
    logic [31:0] dat;
    logic        to;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[8];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic idle_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.u_ack_i   = 1'b0;
    bus.d_ack_i   = 1'b0;
  endtask
  task automatic run(input vec_t v);
    int   k = 0, ustb = 0, dstb = 0, tos = 0;
    bit   done = 0;
    exp_t e;
    sb.push_back('{v.exp_dat, v.exp_to});
    if (v.exp_to && exp_err < 255) exp_err++;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = v.we;
    bus.wbs_sel_i = v.sel;
    bus.wbs_adr_i = v.adr;
    bus.wbs_dat_i = v.wdat;
    @(posedge clk); #1;
    while (!done && k < 300) begin
      if (v.adr_chg && k == 1) bus.wbs_adr_i = 32'h300F_FFF8;
      bus.u_ack_i = (k == v.ack_at && !v.exp_dbg) || (v.wrong && v.exp_dbg);
      bus.d_ack_i = (k == v.ack_at && v.exp_dbg) || (v.wrong && !v.exp_dbg);
      bus.u_dat_i = v.exp_dbg ? 32'hBAD0_BAD0 : v.rdat;
      bus.d_dat_i = v.exp_dbg ? v.rdat : 32'hBAD0_BAD0;
      @(negedge clk);
      if (k == 0) begin
        chk("pass_dat", bus.s_dat_o, v.wdat);
        chk("pass_sel", 32'(bus.s_sel_o), 32'(v.sel));
        chk("pass_we", 32'(bus.s_we_o), 32'(v.we));
        chk("pass_adr", bus.s_adr_o, v.adr);
      end
      ustb += int'(bus.u_stb_o);
      dstb += int'(bus.d_stb_o);
      tos  += int'(timeout_o);
      if (bus.wbs_ack_o) begin
        done = 1;
        chk("latency", 32'(k), 32'(v.exp_stb));
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty actual=ack required=no_ack");
        end else begin
          e = sb.pop_front();
          chk("rdata", bus.wbs_dat_o, e.dat);
          chk("timeout_at_ack", 32'(timeout_o), 32'(e.to));
        end
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL ack_wait actual=none required=ack");
    end
    idle_bus();
    chk("u_stb_cycles", 32'(ustb), 32'(v.exp_dbg ? 0 : v.exp_stb));
    chk("d_stb_cycles", 32'(dstb), 32'(v.exp_dbg ? v.exp_stb : 0));
    chk("timeout_pulses", 32'(tos), 32'(v.exp_to));
    chk("err_cnt", 32'(err_cnt_o), 32'(exp_err));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int acks;
    tbl[0] = '{32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1};
    tbl[1] = '{32'h300F_FFFC, 1'b1, 4'b0101, 32'hA5A5_0001, 2, 32'h0000_0042, 1'b0, 1'b0, 32'h0000_0042, 1'b0, 1'b1, 3};
    tbl[2] = '{32'h3000_0004, 1'b0, 4'hF, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 16};
    tbl[3] = '{32'h3000_0008, 1'b0, 4'hF, 32'h0, 99, 32'h5555_5555, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 16};
    tbl[4] = '{32'h3000_000C, 1'b1, 4'h3, 32'h0BAD_F00D, 3, 32'h1111_2222, 1'b1, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 4};
    tbl[5] = '{32'h3000_0010, 1'b0, 4'hF, 32'h0, 4, 32'h3333_4444, 1'b0, 1'b1, 32'h3333_4444, 1'b0, 1'b0, 5};
    tbl[6] = '{32'h300F_FFF8, 1'b0, 4'hF, 32'h0, 99, 32'h6666_6666, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 16};
    tbl[7] = '{32'h300F_FFFC, 1'b0, 4'hF, 32'h0, 1, 32'h7777_8888, 1'b1, 1'b0, 32'h7777_8888, 1'b0, 1'b1, 2};
    idle_bus();
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.u_dat_i   = 32'h0;
    bus.d_dat_i   = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_err", 32'(err_cnt_o), 32'h0);
    chk("rst_stb", 32'({bus.u_stb_o, bus.u_cyc_o, bus.d_stb_o, bus.d_cyc_o}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tbl[i]) run(tbl[i]);
    // abort: master drops cyc while the user slave is still strobed
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_0020;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_stb", 32'(bus.u_stb_o), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("abort_stb_hold", 32'(bus.u_stb_o), 32'h1);
    @(posedge clk); #1;
    acks = 0;
    @(negedge clk);
    chk("abort_stb_drop", 32'({bus.u_stb_o, bus.d_stb_o}), 32'h0);
    acks += int'(bus.wbs_ack_o) + int'(timeout_o);
    repeat (3) begin
      @(negedge clk);
      acks += int'(bus.wbs_ack_o) + int'(timeout_o);
    end
    chk("abort_no_ack", 32'(acks), 32'h0);
    chk("abort_err", 32'(err_cnt_o), 32'(exp_err));
    @(posedge clk); #1;
    repeat (300) run(tbl[3]);
    chk("err_saturated", 32'(err_cnt_o), 32'd255);
    // reset pulled low between edges while the user slave is strobed
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_0000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy_stb", 32'(bus.u_stb_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stb", 32'({bus.u_stb_o, bus.u_cyc_o, bus.d_stb_o, bus.d_cyc_o}), 32'h0);
    chk("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("mid_rst_dat", bus.wbs_dat_o, 32'h0);
    chk("mid_rst_timeout", 32'(timeout_o), 32'h0);
    chk("mid_rst_err", 32'(err_cnt_o), 32'h0);
    exp_err = 0;
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(tbl[0]);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_slave_mux_ctrl.md
# wb_slave_mux_ctrl

Registered Wishbone transaction controller that sits between the Caravel management Wishbone master and the two user-area slaves: the user project region and the debug-register window. It latches the slave selection at the start of each transaction, sequences the slave strobes, and returns a single registered acknowledge. If a slave does not acknowledge within a bounded number of cycles, it terminates the cycle with an error word, so a missing or hung slave can no longer stall the management core.

## Interface
- `TIMEOUT`, default 16. Cycles in BUSY before the forced termination. Legal range 1..255.
- `DEBUG_TAG`, default 29'h601FFFF. Value of `wbs_adr_i[31:3]` that selects the debug slave.
- `ERR_DATA`, default 32'hDEAD_BEEF. Read data returned on a timeout.
- `wb_clk_i`  in  1  single clock.
- `wb_rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  master cycle, strobe and write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge to the master.
- `wbs_dat_o`  out  32  read data to the master.
- `u_cyc_o`, `u_stb_o`  out  1 each  user-slave cycle and strobe.
- `u_ack_i`  in  1  user-slave acknowledge.
- `u_dat_i`  in  32  user-slave read data.
- `d_cyc_o`, `d_stb_o`  out  1 each  debug-slave cycle and strobe.
- `d_ack_i`  in  1  debug-slave acknowledge.
- `d_dat_i`  in  32  debug-slave read data.
- `s_we_o`, `s_sel_o`, `s_adr_o`, `s_dat_o`  out  1/4/32/32  combinational pass-through of the master's we, sel, adr and write data to both slaves.
- `timeout_o`  out  1  one-cycle pulse on a forced termination.
- `err_cnt_o`  out  8  saturating count of timeouts.

## Operation
**States:** IDLE, BUSY, ACK. Reset state is IDLE.

**IDLE**
- Waits for `wbs_cyc_i & wbs_stb_i`.
- On that condition:
  - latch `sel_dbg = (wbs_adr_i[31:3] == DEBUG_TAG)`;
  - clear the timer;
  - go to BUSY.

**BUSY**
- Strobes of the selected slave:
  - `u_cyc_o = u_stb_o = ~sel_dbg`;
  - `d_cyc_o = d_stb_o = sel_dbg`.
- Strobes of the other slave are 0.
- Priority, evaluated each cycle:
  1. `wbs_cyc_i == 0`: abort, go to IDLE. No ack, no timeout, counter unchanged.
  2. Selected slave ack is 1: capture the selected slave's read data, go to ACK.
  3. `timer == TIMEOUT-1`: capture ERR_DATA, set the timeout flag, go to ACK.
  4. Otherwise: increment the timer.
- The ack of the unselected slave is ignored in all states.

**ACK**
- `wbs_ack_o = 1` and `wbs_dat_o` = captured word.
- `timeout_o = 1` only if the cycle was terminated by timeout.
- All slave strobes are 0.
- Always go to IDLE next cycle.

**Outputs outside ACK:** `wbs_ack_o = 0`, `wbs_dat_o = 0`, `timeout_o = 0`.

**Error counter:** `err_cnt_o` increments on entry to ACK via timeout and saturates at 255. It is cleared only by reset.

**Address changes:** once the machine is in BUSY, changes on `wbs_adr_i` do not change the slave selection.

**Writes:** sequenced identically to reads. On a write the captured data is don't-care, but it is still driven during ACK.

## Timing
**Reset:** asserting `wb_rst_n_i` low forces the following immediately, without a clock edge:
- state = IDLE;
- all slave cyc/stb = 0;
- `wbs_ack_o = 0`, `wbs_dat_o = 0`;
- `timeout_o = 0`, `err_cnt_o = 0`;
- timer = 0.

Reset asserted mid-transaction drops the slave strobes immediately; no ack is produced.

**Cycle numbering:** the edge at which IDLE samples cyc&stb = edge 0.
- BUSY is visible in the cycle after edge 0.
- A slave ack sampled at edge 1 (same cycle as its strobe) produces `wbs_ack_o` in the cycle after edge 1. This is the minimum 2-cycle request-to-ack latency.

**Timeout:** with a slave that never acks, `wbs_ack_o` and `timeout_o` rise after edge TIMEOUT, and the slave strobes stay high for exactly TIMEOUT cycles.

**Ack and timer expiry in the same cycle:** the slave ack wins, no timeout is counted, and the slave data is returned.

**Back-to-back:** a new request sampled in the IDLE cycle immediately after ACK is accepted. The minimum spacing is 3 cycles per transaction.

**Timer:** width is 8 bits; the 255 limit of TIMEOUT comes from this width.

## Test plan
- **User read:** read with adr=32'h3000_0000; the user slave acks in its first strobe cycle with 32'h1234_5678 -> `u_stb_o` high for 1 cycle, `d_stb_o` stays 0, `wbs_ack_o` high 1 cycle at latency 2, `wbs_dat_o`=32'h1234_5678, `timeout_o`=0.
- **Debug write:** write with adr=32'h300F_FFFC (adr[31:3]=29'h601FFFF) -> `d_cyc_o`/`d_stb_o` asserted, `s_dat_o`/`s_sel_o` equal the master's values, `u_stb_o` stays 0, ack returned.
- **Timeout:** TIMEOUT=16 and the user slave never acks -> strobes high for exactly 16 cycles, then `wbs_ack_o`=1 with `wbs_dat_o`=32'hDEAD_BEEF, `timeout_o` pulses once, `err_cnt_o`=1. Repeat 300 times -> `err_cnt_o` saturates at 255.
- **Ack/timeout tie and wrong-slave ack:** slave ack in the same cycle as timer expiry -> slave data returned, `err_cnt_o` unchanged. Debug slave acks while the user slave is selected -> ignored, and the user slave's ack still completes the cycle.
- **Abort and address change:** master drops `wbs_cyc_i` in BUSY -> strobes drop next cycle, no ack, counter unchanged. Address switched to the debug window during BUSY -> selection stays on the user slave.
- **Reset mid-transaction:** `wb_rst_n_i` pulled low in BUSY between clock edges -> strobes and all outputs go to 0 immediately. After release, a new read completes normally.
